mem_burst_splitter: RTL and testbench
=====================================

Name: mem_burst_splitter

Overview:
- Generalised successor to the 4 KB request splitter on the memory-request path, sitting between a tile/stream address generator and the AXI address channel.
- Splits one request into N chunks. No chunk crosses a 2^BOUNDARY_LOG2 byte boundary, and no chunk exceeds 2^MAX_BURST_LOG2 bytes.
- Uses valid/ready handshakes on both sides instead of the fixed two-chunk sequence with a ready/pop pair.

Parameters:
- ADDR_WIDTH, 64, byte address width.
- REQ_SIZE_WIDTH, 16, request/chunk size width in bytes.
- BOUNDARY_LOG2, 12, log2 of the no-cross boundary (12 = AXI 4 KB).
- MAX_BURST_LOG2, 12, log2 of the maximum chunk size. Requires MAX_BURST_LOG2 <= BOUNDARY_LOG2 and MAX_BURST_LOG2 < REQ_SIZE_WIDTH; an elaboration-time assertion checks this.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_addr  in  ADDR_WIDTH  request start byte address
- in_size  in  REQ_SIZE_WIDTH  request size in bytes
- out_valid  out  1  chunk valid
- out_ready  in  1  downstream accepts chunk
- out_addr  out  ADDR_WIDTH  chunk address
- out_size  out  REQ_SIZE_WIDTH  chunk size in bytes
- out_first  out  1  chunk is first of its request
- out_last  out  1  chunk is last of its request
- busy  out  1  request in flight (state != IDLE)
- req_done  out  1  one-cycle pulse when the last chunk is accepted or a zero-size request is dropped

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Reset values: in_ready=1, out_valid=0, out_addr=0, out_size=0, out_first=0, out_last=0, busy=0, req_done=0; cur_addr=0, remaining=0.
- States: IDLE, ISSUE.
  - IDLE: in_ready=1.
    - On acceptance with in_size!=0: latch cur_addr=in_addr and remaining=in_size, load chunk 0 into the output registers, set out_first=1, go to ISSUE.
    - On acceptance with in_size==0: pulse req_done the next cycle, stay in IDLE, emit no chunk.
  - ISSUE: out_valid=1, in_ready=0 (see Optional Feature).
    - On out_valid && out_ready with !out_last: cur_addr += out_size, remaining -= out_size, load the next chunk, clear out_first.
    - On out_valid && out_ready with out_last: go to IDLE, out_valid=0, req_done=1 for one cycle.
- Chunk calculation (combinational, from cur_addr/remaining):
  - to_bnd = 2^BOUNDARY_LOG2 - cur_addr[BOUNDARY_LOG2-1:0], computed in BOUNDARY_LOG2+1 bits; an aligned address gives a full boundary.
  - size = min(remaining, to_bnd, 2^MAX_BURST_LOG2).
  - last = (size == remaining).
- Latency: acceptance in cycle N gives out_valid in cycle N+1. Each subsequent chunk follows in the cycle after the prior handshake, so back-to-back chunks run at 1 per cycle while out_ready=1.
- Stability: out_addr, out_size, out_first and out_last are held constant while out_valid && !out_ready.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap at the top of the address space is not an error.
- Chunk count is bounded by ceil(in_size / 2^MAX_BURST_LOG2) + 1.
- Reset mid-request aborts immediately: no further chunks and no req_done.
- in_valid while busy is ignored (not accepted). in_addr and in_size only need to be valid in the acceptance cycle.

Optional Feature:
- Macro: MEM_BURST_SPLITTER_PIPELINE_EN.
- Defined:
  - in_ready = IDLE || (out_valid && out_ready && out_last).
  - A new request can be accepted in the same cycle as the last-chunk handshake. The FSM stays in ISSUE, loads the new chunk 0 and sets out_first.
  - req_done still pulses for the completed request. A simultaneously accepted zero-size request gives a second req_done pulse in the following cycle.
  - No idle bubble between requests.
- Undefined: in_ready = IDLE only, giving one bubble cycle between requests.

Decomposition:
- Package mem_split_pkg:
  - state enum (IDLE, ISSUE);
  - localparam helpers for boundary and max-burst byte counts;
  - function chunk_size(addr_lsbs, remaining) returning {size, last}.
- One sub-module, mem_split_chunk_calc: purely combinational chunk computation, reused by the load-store address generators.

Test Plan:
- addr 0x0FC0, size 0x100 (BOUNDARY_LOG2=12, MAX_BURST_LOG2=12) -> chunks {0x0FC0, 0x40, first} then {0x1000, 0xC0, last}; req_done once.
- addr 0x2000, size 0x2000 -> {0x2000, 0x1000, first} then {0x3000, 0x1000, last}; the aligned start must not create an extra chunk.
- MAX_BURST_LOG2=8; addr 0x10, size 0x300 -> three chunks {0x10, 0x100}, {0x110, 0x100}, {0x210, 0x100}; out_last only on the third.
- Randomly deassert out_ready during a 3-chunk request -> outputs stable while stalled, no chunk lost or duplicated, chunk sizes sum to in_size.
- in_size=0 -> no out_valid; req_done one cycle after acceptance. Reset asserted between chunk 1 and chunk 2 -> out_valid=0 next cycle, no req_done.
- With MEM_BURST_SPLITTER_PIPELINE_EN: two back-to-back requests with out_ready=1 -> zero idle cycles between the last chunk of request 1 and the first of request 2. Without the macro -> exactly one bubble.

Source files
------------

// File: rtl/mem_split_pkg.sv
// Shared types and chunk arithmetic for the memory burst splitter and the
// load-store address generators that reuse the same chunk rule.
package mem_split_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  localparam int unsigned CALC_W             = 64;
  localparam int unsigned DEF_BOUNDARY_LOG2  = 12;
  localparam int unsigned DEF_MAX_BURST_LOG2 = 12;

  typedef struct packed {
    logic [CALC_W-1:0] size;
    logic              last;
  } chunk_t;

  function automatic logic [CALC_W-1:0] boundary_bytes(input int unsigned lg);
    return CALC_W'(1) << lg;
  endfunction

  function automatic logic [CALC_W-1:0] max_burst_bytes(input int unsigned lg);
    return CALC_W'(1) << lg;
  endfunction

  // An aligned address yields a full boundary window rather than zero.
  function automatic chunk_t chunk_size(input logic [CALC_W-1:0] addr_lsbs,
                                        input logic [CALC_W-1:0] remaining,
                                        input int unsigned       bnd_log2,
                                        input int unsigned       max_log2);
    logic [CALC_W-1:0] bnd;
    logic [CALC_W-1:0] to_bnd;
    logic [CALC_W-1:0] sz;
    chunk_t            res;
    bnd    = boundary_bytes(bnd_log2);
    to_bnd = bnd - (addr_lsbs & (bnd - CALC_W'(1)));
    sz     = remaining;
    if (to_bnd < sz) sz = to_bnd;
    if (max_burst_bytes(max_log2) < sz) sz = max_burst_bytes(max_log2);
    res.size = sz;
    res.last = (sz == remaining);
    return res;
  endfunction

endpackage

// File: rtl/mem_split_chunk_calc.sv
// Combinational chunk computation: size of the next chunk from the current
// address and remaining byte count, and whether it finishes the request.
module mem_split_chunk_calc
  import mem_split_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned REQ_SIZE_WIDTH = 16,
  parameter int unsigned BOUNDARY_LOG2  = DEF_BOUNDARY_LOG2,
  parameter int unsigned MAX_BURST_LOG2 = DEF_MAX_BURST_LOG2
) (
  input  logic [ADDR_WIDTH-1:0]     cur_addr_i,
  input  logic [REQ_SIZE_WIDTH-1:0] remaining_i,
  output logic [REQ_SIZE_WIDTH-1:0] chunk_size_o,
  output logic                      chunk_last_o
);

  chunk_t res;
  logic   unused_bits;

  assign res = chunk_size(CALC_W'(cur_addr_i[BOUNDARY_LOG2-1:0]),
                          CALC_W'(remaining_i),
                          BOUNDARY_LOG2, MAX_BURST_LOG2);

  // The chunk never exceeds remaining, so the narrow slice is lossless.
  assign chunk_size_o = res.size[REQ_SIZE_WIDTH-1:0];
  assign chunk_last_o = res.last;

  assign unused_bits = ^{res.size[CALC_W-1:REQ_SIZE_WIDTH],
                         cur_addr_i[ADDR_WIDTH-1:BOUNDARY_LOG2]};

endmodule

// File: rtl/mem_burst_splitter.sv
// Splits one memory request into boundary- and burst-limited chunks.
// Define MEM_BURST_SPLITTER_PIPELINE_EN to accept the next request on the last-chunk handshake.
module mem_burst_splitter
  import mem_split_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned REQ_SIZE_WIDTH = 16,
  parameter int unsigned BOUNDARY_LOG2  = DEF_BOUNDARY_LOG2,
  parameter int unsigned MAX_BURST_LOG2 = DEF_MAX_BURST_LOG2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_WIDTH-1:0]     in_addr,
  input  logic [REQ_SIZE_WIDTH-1:0] in_size,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_WIDTH-1:0]     out_addr,
  output logic [REQ_SIZE_WIDTH-1:0] out_size,
  output logic                      out_first,
  output logic                      out_last,
  output logic                      busy,
  output logic                      req_done
);

  if (!(MAX_BURST_LOG2 <= BOUNDARY_LOG2 && MAX_BURST_LOG2 < REQ_SIZE_WIDTH)) begin : g_bad_params
    $error("mem_burst_splitter: need MAX_BURST_LOG2 <= BOUNDARY_LOG2 and MAX_BURST_LOG2 < REQ_SIZE_WIDTH");
  end

  state_e                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     cur_addr_q, cur_addr_d;
  logic [REQ_SIZE_WIDTH-1:0] remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0]     out_addr_q, out_addr_d;
  logic [REQ_SIZE_WIDTH-1:0] out_size_q, out_size_d;
  logic                      out_first_q, out_first_d;
  logic                      out_last_q, out_last_d;
  logic                      req_done_q, req_done_d;
  logic                      done_pend_q, done_pend_d;

  logic                      out_hs, last_hs, adv_hs, accept, zero_acc;
  logic [ADDR_WIDTH-1:0]     adv_addr, calc_addr;
  logic [REQ_SIZE_WIDTH-1:0] adv_rem, calc_rem, calc_size;
  logic                      calc_last;
  logic [1:0]                done_cnt;

  assign out_hs  = (state_q == ISSUE) && out_ready;
  assign last_hs = out_hs && out_last_q;
  assign adv_hs  = out_hs && !out_last_q;

`ifdef MEM_BURST_SPLITTER_PIPELINE_EN
  assign in_ready = (state_q == IDLE) || last_hs;
`else
  assign in_ready = (state_q == IDLE);
`endif

  assign accept   = in_valid && in_ready;
  assign zero_acc = accept && (in_size == '0);

  // One calculator serves both the advance and the fresh-request load;
  // the two can never happen in the same cycle.
  assign adv_addr  = cur_addr_q + ADDR_WIDTH'(out_size_q);
  assign adv_rem   = remaining_q - out_size_q;
  assign calc_addr = adv_hs ? adv_addr : in_addr;
  assign calc_rem  = adv_hs ? adv_rem : in_size;

  mem_split_chunk_calc #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .REQ_SIZE_WIDTH(REQ_SIZE_WIDTH),
    .BOUNDARY_LOG2 (BOUNDARY_LOG2),
    .MAX_BURST_LOG2(MAX_BURST_LOG2)
  ) u_calc (
    .cur_addr_i  (calc_addr),
    .remaining_i (calc_rem),
    .chunk_size_o(calc_size),
    .chunk_last_o(calc_last)
  );

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    out_addr_d  = out_addr_q;
    out_size_d  = out_size_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;

    if (adv_hs) begin
      cur_addr_d  = adv_addr;
      remaining_d = adv_rem;
      out_addr_d  = adv_addr;
      out_size_d  = calc_size;
      out_last_d  = calc_last;
      out_first_d = 1'b0;
    end

    if (last_hs) begin
      state_d     = IDLE;
      remaining_d = adv_rem;
    end

    // Placed after the last-handshake branch so a pipelined accept wins.
    if (accept && (in_size != '0)) begin
      state_d     = ISSUE;
      cur_addr_d  = in_addr;
      remaining_d = in_size;
      out_addr_d  = in_addr;
      out_size_d  = calc_size;
      out_last_d  = calc_last;
      out_first_d = 1'b1;
    end

    // Two completions in one cycle spill the second pulse into the next.
    done_cnt    = {1'b0, last_hs} + {1'b0, zero_acc} + {1'b0, done_pend_q};
    req_done_d  = (done_cnt != 2'd0);
    done_pend_d = done_cnt[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      out_addr_q  <= '0;
      out_size_q  <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      req_done_q  <= 1'b0;
      done_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      out_addr_q  <= out_addr_d;
      out_size_q  <= out_size_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      req_done_q  <= req_done_d;
      done_pend_q <= done_pend_d;
    end
  end

  assign out_valid = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);
  assign out_addr  = out_addr_q;
  assign out_size  = out_size_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign req_done  = req_done_q;

endmodule

// File: tb/tb_mem_burst_splitter.sv
// Directed and random checks of mem_burst_splitter against a chunk-list model;
// instance 0 uses 4 KB bursts, instance 1 uses 256-byte bursts.
module tb_mem_burst_splitter;

  localparam int AW = 64;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          in_valid [2];
  logic          in_ready [2];
  logic [AW-1:0] in_addr  [2];
  logic [SW-1:0] in_size  [2];
  logic          out_valid[2];
  logic          out_ready[2];
  logic [AW-1:0] out_addr [2];
  logic [SW-1:0] out_size [2];
  logic          out_first[2];
  logic          out_last [2];
  logic          busy     [2];
  logic          req_done [2];

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_addr[$];
  int            exp_size[$];

  mem_burst_splitter #(.ADDR_WIDTH(AW), .REQ_SIZE_WIDTH(SW), .BOUNDARY_LOG2(12), .MAX_BURST_LOG2(12)) dut0 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_addr(in_addr[0]), .in_size(in_size[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_addr(out_addr[0]), .out_size(out_size[0]),
    .out_first(out_first[0]), .out_last(out_last[0]), .busy(busy[0]), .req_done(req_done[0])
  );

  mem_burst_splitter #(.ADDR_WIDTH(AW), .REQ_SIZE_WIDTH(SW), .BOUNDARY_LOG2(12), .MAX_BURST_LOG2(8)) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_addr(in_addr[1]), .in_size(in_size[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_addr(out_addr[1]), .out_size(out_size[1]),
    .out_first(out_first[1]), .out_last(out_last[1]), .busy(busy[1]), .req_done(req_done[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected chunk list: walk the request, cutting at 4 KB lines and the burst cap.
  task automatic model_split(input int d, input logic [AW-1:0] a, input logic [SW-1:0] s);
    int            maxb, rem, to_b, sz;
    logic [AW-1:0] cur;
    exp_addr.delete();
    exp_size.delete();
    maxb = (d == 0) ? 4096 : 256;
    rem  = int'(s);
    cur  = a;
    while (rem > 0) begin
      to_b = 4096 - int'(cur[11:0]);
      sz   = rem;
      if (to_b < sz) sz = to_b;
      if (maxb < sz) sz = maxb;
      exp_addr.push_back(cur);
      exp_size.push_back(sz);
      cur = cur + 64'(sz);
      rem = rem - sz;
    end
  endtask

  task automatic run_req(input int d, input logic [AW-1:0] a, input logic [SW-1:0] s,
                         input int unsigned stall_pct);
    logic [63:0] sum;
    int          idx, n, budget;
    logic        hs;
    model_split(d, a, s);
    n = exp_addr.size();
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready[d]), 64'd1);
    in_valid[d] = 1'b1;
    in_addr[d]  = a;
    in_size[d]  = s;
    @(negedge clk);
    in_valid[d] = 1'b0;
    in_addr[d]  = {$urandom, $urandom};
    in_size[d]  = SW'($urandom);
    idx = 0;
    sum = '0;
    budget = 2000;
    while (idx < n && budget > 0) begin
      chk("out_valid", 64'(out_valid[d]), 64'd1);
      chk("busy", 64'(busy[d]), 64'd1);
      chk("out_addr", out_addr[d], exp_addr[idx]);
      chk("out_size", 64'(out_size[d]), 64'(exp_size[idx]));
      chk("out_first", 64'(out_first[d]), 64'(idx == 0));
      chk("out_last", 64'(out_last[d]), 64'(idx == n - 1));
      chk("req_done_early", 64'(req_done[d]), 64'd0);
`ifndef MEM_BURST_SPLITTER_PIPELINE_EN
      chk("in_ready_busy", 64'(in_ready[d]), 64'd0);
`endif
      hs = ($urandom_range(0, 99) >= stall_pct);
      out_ready[d] = hs;
      if (hs) sum = sum + 64'(out_size[d]);
      @(negedge clk);
      if (hs) idx++;
      budget--;
    end
    out_ready[d] = 1'b0;
    chk("chunk_count", 64'(idx), 64'(n));
    chk("size_sum", sum, 64'(s));
    chk("req_done_pulse", 64'(req_done[d]), 64'd1);
    chk("out_valid_after", 64'(out_valid[d]), 64'd0);
    @(negedge clk);
    chk("req_done_single", 64'(req_done[d]), 64'd0);
    $display("req dut%0d addr=%h size=%h chunks=%0d checks=%0d errors=%0d", d, a, s, n, checks, errors);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [SW-1:0] rs;
    int            gap, c, exp_gap;
    logic          seen_b, acc;

    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      in_addr[d]   = '0;
      in_size[d]   = '0;
      out_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", 64'(in_ready[d]), 64'd1);
      chk("rst_out_valid", 64'(out_valid[d]), 64'd0);
      chk("rst_out_addr", out_addr[d], 64'd0);
      chk("rst_out_size", 64'(out_size[d]), 64'd0);
      chk("rst_first_last", 64'({out_first[d], out_last[d]}), 64'd0);
      chk("rst_busy", 64'(busy[d]), 64'd0);
      chk("rst_req_done", 64'(req_done[d]), 64'd0);
    end
    reset = 1'b0;

    run_req(0, 64'h0FC0, 16'h0100, 0);
    run_req(0, 64'h2000, 16'h2000, 0);
    run_req(1, 64'h0010, 16'h0300, 0);
    run_req(1, 64'h0010, 16'h0300, 50);
    run_req(0, 64'h1234, 16'h0000, 0);
    run_req(0, 64'hFFFF_FFFF_FFFF_FFC0, 16'h0100, 20);
    run_req(1, 64'h0F80, 16'h1000, 40);

    // Reset between chunk 1 and chunk 2 aborts the request silently.
    @(negedge clk);
    in_valid[1] = 1'b1;
    in_addr[1]  = 64'h10;
    in_size[1]  = 16'h300;
    @(negedge clk);
    in_valid[1] = 1'b0;
    chk("abort_chunk0_addr", out_addr[1], 64'h10);
    out_ready[1] = 1'b1;
    @(negedge clk);
    chk("abort_chunk1_addr", out_addr[1], 64'h110);
    out_ready[1] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_out_valid", 64'(out_valid[1]), 64'd0);
    chk("abort_busy", 64'(busy[1]), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", 64'(req_done[1]), 64'd0);
      chk("abort_no_valid", 64'(out_valid[1]), 64'd0);
      @(negedge clk);
    end
    $display("abort dut1 checks=%0d errors=%0d", checks, errors);

    // Back-to-back single-chunk requests with the sink always ready.
`ifdef MEM_BURST_SPLITTER_PIPELINE_EN
    exp_gap = 0;
`else
    exp_gap = 1;
`endif
    in_valid[0]  = 1'b1;
    in_addr[0]   = 64'h100;
    in_size[0]   = 16'h40;
    out_ready[0] = 1'b1;
    @(negedge clk);
    in_addr[0] = 64'h200;
    gap = 0;
    c = 0;
    seen_b = 1'b0;
    while (!seen_b && c < 8) begin
      if (out_valid[0] && out_addr[0] == 64'h200) begin
        seen_b = 1'b1;
      end else begin
        if (!out_valid[0]) gap++;
        acc = in_valid[0] && in_ready[0];
        @(negedge clk);
        if (acc) in_valid[0] = 1'b0;
        c++;
      end
    end
    in_valid[0] = 1'b0;
    chk("b2b_second_seen", 64'(seen_b), 64'd1);
    chk("b2b_gap", 64'(gap), 64'(exp_gap));
    chk("b2b_second_first", 64'(out_first[0]), 64'd1);
    chk("b2b_second_size", 64'(out_size[0]), 64'h40);
    @(negedge clk);
    out_ready[0] = 1'b0;
    chk("b2b_done", 64'(req_done[0]), 64'd1);
    chk("b2b_idle", 64'(out_valid[0]), 64'd0);
    @(negedge clk);
    $display("b2b dut0 gap=%0d checks=%0d errors=%0d", gap, checks, errors);

    for (int i = 0; i < 24; i++) begin
      ra = {$urandom, $urandom};
      if (i % 3 == 0) ra[11:0] = 12'hFFF - 12'($urandom_range(0, 63));
      rs = 16'($urandom_range(0, 16'h3000));
      if (i % 8 == 5) rs = '0;
      run_req(i % 2, ra, rs, 30);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
